// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoder control bundle and ALUOp encodings.
// Imported by the ID/EX register slice and its hazard detector.
package pipe_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_UJ  = 2'b11;

  typedef struct packed {
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;
    logic       ForceBranch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load and ID reader.
// Ports: EX slot valid/MemRead/rd, ID valid, rs1/rs2 with used flags -> o_hazard.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_rs1,
  input  logic       i_rs1_used,
  input  logic [4:0] i_rs2,
  input  logic       i_rs2_used,
  output logic       o_hazard
);

  logic w_ex_load;
  logic w_hit1;
  logic w_hit2;

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign w_ex_load = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0);
  assign w_hit1    = i_rs1_used & (i_rs1 == i_ex_rd);
  assign w_hit2    = i_rs2_used & (i_rs2 == i_ex_rd);
  assign o_hazard  = w_ex_load & i_id_valid & (w_hit1 | w_hit2);

endmodule

// File: rtl/id_ex_ctrl_reg.sv
// ID/EX control register with load-use stall, redirect flush and counters.
// Ports: clk/reset, ID bundle in, ex_redirect; EX bundle, stall, flush_ifid, counters out.
module id_ex_ctrl_reg
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  ctrl_t            id_ctrl,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_redirect,
  output logic             ex_valid,
  output ctrl_t            ex_ctrl,
  output logic [4:0]       ex_rd,
  output logic             stall,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             r_ex_valid;
  ctrl_t            r_ex_ctrl;
  logic [4:0]       r_ex_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  load_use_detect u_lud (
    .i_ex_valid   (r_ex_valid),
    .i_ex_memread (r_ex_ctrl.MemRead),
    .i_ex_rd      (r_ex_rd),
    .i_id_valid   (id_valid),
    .i_rs1        (id_rs1),
    .i_rs1_used   (id_rs1_used),
    .i_rs2        (id_rs2),
    .i_rs2_used   (id_rs2_used),
    .o_hazard     (w_hazard)
  );

  // redirect wins: the dependent instruction is squashed anyway
  assign w_stall  = w_hazard & ~ex_redirect;
  assign w_bubble = w_stall | ex_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= CTRL_NOP;
      r_ex_rd    <= 5'd0;
    end else if (w_bubble) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= CTRL_NOP;
      r_ex_rd    <= 5'd0;
    end else begin
      r_ex_valid <= id_valid;
      // invalid slots must not carry write/memory side effects
      r_ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
      r_ex_rd    <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ex_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_ctrl    = r_ex_ctrl;
  assign ex_rd      = r_ex_rd;
  assign stall      = w_stall;
  assign flush_ifid = ex_redirect;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_reg.sv
// Self-checking bench for id_ex_ctrl_reg: directed hazard cases plus random.
// A second narrow-counter instance shares the stimulus to exercise saturation.
module tb_id_ex_ctrl_reg;
  import pipe_pkg::*;

  localparam int W  = 16;
  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  ctrl_t       id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic        ex_redirect;

  logic        ex_valid;
  ctrl_t       ex_ctrl;
  logic [4:0]  ex_rd;
  logic        stall, flush_ifid;
  logic [W-1:0] stall_cnt, flush_cnt;

  logic        s_ex_valid;
  ctrl_t       s_ex_ctrl;
  logic [4:0]  s_ex_rd;
  logic        s_stall, s_flush;
  logic [SW-1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  id_ex_ctrl_reg #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_redirect(ex_redirect), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rd(ex_rd), .stall(stall), .flush_ifid(flush_ifid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_ctrl_reg #(.CNT_W(SW)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_redirect(ex_redirect), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl),
    .ex_rd(s_ex_rd), .stall(s_stall), .flush_ifid(s_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int checks = 0;
  int failures = 0;

  // reference model: contents of the EX slot and raw event totals
  logic  m_valid;
  ctrl_t m_ctrl;
  logic [4:0] m_rd;
  int    m_stall_n;
  int    m_flush_n;
  logic  last_stall;

  ctrl_t C_LW, C_ADD, C_SW;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return 32'((n > mx) ? mx : n);
  endfunction

  task automatic step(input logic v, input ctrl_t c,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic u1, input logic u2,
                      input logic redir, input logic rst);
    logic hz, es;
    id_valid = v; id_ctrl = c;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_used = u1; id_rs2_used = u2;
    ex_redirect = redir; reset = rst;
    #1;
    hz = m_valid && m_ctrl.MemRead && (m_rd != 0) && v &&
         ((u1 && r1 == m_rd) || (u2 && r2 == m_rd));
    es = hz && !redir;
    last_stall = es;
    chk("stall", 32'(stall), 32'(es));
    chk("flush_ifid", 32'(flush_ifid), 32'(redir));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_rd = 0;
      m_stall_n = 0; m_flush_n = 0;
    end else begin
      if (es) m_stall_n++;
      if (redir) m_flush_n++;
      if (es || redir) begin
        m_valid = 0; m_ctrl = '0; m_rd = 0;
      end else begin
        m_valid = v; m_ctrl = v ? c : ctrl_t'(0); m_rd = rd;
      end
    end
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
    chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    chk("stall_cnt", 32'(stall_cnt), sat(m_stall_n, W));
    chk("flush_cnt", 32'(flush_cnt), sat(m_flush_n, W));
    chk("s_stall_cnt", 32'(s_stall_cnt), sat(m_stall_n, SW));
    chk("s_flush_cnt", 32'(s_flush_cnt), sat(m_flush_n, SW));
  endtask

  initial begin
    C_LW  = '{ALUSrc:1'b1, MemtoReg:1'b1, RegWrite:1'b1, MemRead:1'b1,
              MemWrite:1'b0, ALUOp:ALUOP_MEM, Branch:1'b0, ForceBranch:1'b0};
    C_ADD = '{ALUSrc:1'b0, MemtoReg:1'b0, RegWrite:1'b1, MemRead:1'b0,
              MemWrite:1'b0, ALUOp:ALUOP_RI, Branch:1'b0, ForceBranch:1'b0};
    C_SW  = '{ALUSrc:1'b1, MemtoReg:1'b0, RegWrite:1'b0, MemRead:1'b0,
              MemWrite:1'b1, ALUOp:ALUOP_MEM, Branch:1'b0, ForceBranch:1'b0};

    reset = 1; id_valid = 0; id_ctrl = '0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_redirect = 0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 0; m_ctrl = '0; m_rd = 0;
    m_stall_n = 0; m_flush_n = 0; last_stall = 0;

    // reset state, then first cycle out of reset
    step(1, C_ADD, 1, 2, 3, 1, 1, 0, 1);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0);

    // LW x5 ; ADD x6,x5,x1
    step(1, C_LW, 1, 0, 5, 1, 0, 0, 0);
    step(1, C_ADD, 5, 1, 6, 1, 1, 0, 0);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    step(1, C_ADD, 5, 1, 6, 1, 1, 0, 0);
    chk("lu_add_ex", 32'(ex_rd), 32'd6);

    // LW x0 ; ADD reading x0
    step(1, C_LW, 1, 0, 0, 1, 0, 0, 0);
    step(1, C_ADD, 0, 0, 6, 1, 1, 0, 0);
    chk("x0_nostall", 32'(last_stall), 32'd0);
    chk("x0_cnt", 32'(stall_cnt), 32'd1);

    // hazard coinciding with redirect
    step(1, C_LW, 1, 0, 5, 1, 0, 0, 0);
    step(1, C_ADD, 5, 1, 6, 1, 1, 1, 0);
    chk("rd_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("rd_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("rd_bubble", 32'(ex_valid), 32'd0);

    // SW rs2 match with and without rs2_used
    step(1, C_LW, 1, 0, 7, 1, 0, 0, 0);
    step(1, C_SW, 2, 7, 0, 1, 0, 0, 0);
    chk("sw_unused", 32'(last_stall), 32'd0);
    step(1, C_LW, 1, 0, 7, 1, 0, 0, 0);
    step(1, C_SW, 2, 7, 0, 1, 1, 0, 0);
    chk("sw_used", 32'(last_stall), 32'd1);
    step(1, C_SW, 2, 7, 0, 1, 1, 0, 0);

    // reset during a stall cycle
    step(1, C_LW, 1, 0, 5, 1, 0, 0, 0);
    step(1, C_ADD, 5, 1, 6, 1, 1, 0, 1);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    step(1, C_ADD, 5, 1, 6, 1, 1, 0, 0);
    chk("rst_nostall", 32'(last_stall), 32'd0);

    // drive the narrow counters past saturation
    for (int i = 0; i < 40; i++) begin
      step(1, C_LW, 1, 0, 3, 1, 0, 0, 0);
      step(1, C_ADD, 3, 2, 4, 1, 0, 0, 0);
    end
    for (int i = 0; i < 20; i++)
      step(1, C_ADD, 1, 2, 4, 1, 1, 1, 0);
    chk("sat_stall", 32'(s_stall_cnt), 32'd15);
    chk("sat_flush", 32'(s_flush_cnt), 32'd15);
    chk("wide_stall", 32'(stall_cnt), 32'd40);

    // random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic v, rdr, rs;
      ctrl_t c;
      v   = ($urandom_range(0, 9) < 8);
      rdr = ($urandom_range(0, 9) == 0);
      rs  = ($urandom_range(0, 49) == 0);
      c   = ctrl_t'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) c.MemRead = 1'b1;
      step(v, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), rdr, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_reg.md
ID_EX_CTRL_REG -- requirements
Module: id_ex_ctrl_reg

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_ctrl  input  ctrl_t  decoder bundle: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, ForceBranch.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  ID register indices.
REQ-007 id_rs1_used, id_rs2_used  input  1 each  operand actually read by the ID instruction.
REQ-008 ex_redirect  input  1  EX resolved a taken branch/jump this cycle.
REQ-009 ex_valid  output  1  EX slot holds a real instruction.
REQ-010 ex_ctrl  output  ctrl_t  registered control bundle for EX.
REQ-011 ex_rd  output  5  registered destination index.
REQ-012 stall  output  1  hold PC and IF/ID register this cycle.
REQ-013 flush_ifid  output  1  squash IF/ID contents at next edge.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-015 Load-use hazard (combinational) SHALL be: ex_valid & ex_ctrl.MemRead & ex_rd!=0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-016 stall SHALL equal hazard & ~ex_redirect; flush_ifid SHALL equal ex_redirect.
REQ-017 Normal edge (no stall, no redirect): ex_valid<=id_valid, ex_ctrl<=id_ctrl, ex_rd<=id_rd; latency exactly one cycle.
REQ-018 Stall edge: bubble inserted -- ex_valid<=0, ex_ctrl<=all zeros, ex_rd<=0; ID contents preserved upstream by stall.
REQ-019 Redirect edge: bubble inserted as in REQ-018 regardless of hazard; redirect has priority over stall.
REQ-020 When id_valid=0, ex_ctrl SHALL be registered as all zeros (no write or memory side effects leak from invalid slots).
REQ-021 Stall lasts exactly one cycle per load-use pair: after the bubble, ex_ctrl.MemRead=0 so hazard deasserts.
REQ-022 stall_cnt increments by 1 on each cycle stall=1; flush_cnt increments by 1 on each cycle flush_ifid=1; both saturate at all-ones, no wrap.
REQ-023 rd=0 never triggers a hazard (x0 hardwired).

Reset
REQ-024 While reset=1 at an edge: ex_valid=0, ex_ctrl=0, ex_rd=0, stall_cnt=0, flush_cnt=0.
REQ-025 Outputs stall and flush_ifid SHALL be 0 in the cycle after reset (derived from cleared state, ex_redirect assumed 0 by upstream).
REQ-026 Reset asserted mid-stall SHALL discard the pending bubble/hold; no residual stall after reset release.

Structure
REQ-027 ctrl_t packed struct and ALUOp encodings (00 LW/SW, 01 branch, 10 R/I-type, 11 U/JALR) SHALL live in shared package pipe_pkg.
REQ-028 Hazard compare SHALL be a sub-module load_use_detect (purely combinational); counters inline.

Verification
REQ-029 LW x5 then ADD x6,x5,x1 (rs1_used=1) -> stall=1 one cycle, ex_valid=0 next edge, stall_cnt=1, ADD enters EX following edge.
REQ-030 LW x0 then ADD using x0 -> stall=0, no bubble, stall_cnt=0.
REQ-031 Hazard and ex_redirect same cycle -> stall=0, flush_ifid=1, bubble in EX, flush_cnt=1, stall_cnt unchanged.
REQ-032 LW x7 then SW with rs2=x7 but rs2_used=0 -> no stall; with rs2_used=1 -> one stall.
REQ-033 Force 2^CNT_W+3 stall events -> stall_cnt holds 16'hFFFF (CNT_W=16).
REQ-034 Assert reset during stall cycle -> next cycle ex_valid=0, counters 0, stall=0.
